// File: rtl/rf_pkg.sv
// Shared widths and the writeback queue entry type used by rf_wb_queue
// and its forwarding matcher.
package rf_pkg;

  localparam int SEL_W    = 3;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic              valid;
    logic [SEL_W-1:0]  regsel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fwd_match.sv
// Priority matcher for one rf read selector: youngest queued entry wins,
// then the output register; no match gives hit=0, data=0.
module rf_wb_fwd_match #(
  parameter int DEPTH = 4
) (
  input  rf_pkg::wb_entry_t [DEPTH-1:0]  entries,   // index 0 = youngest
  input  rf_pkg::wb_entry_t              out_entry, // valid = rf write in flight
  input  logic [rf_pkg::SEL_W-1:0]       sel,
  output logic                           hit,
  output logic [rf_pkg::DATA_W-1:0]      data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (out_entry.valid && (out_entry.regsel == sel)) begin
      hit  = 1'b1;
      data = out_entry.data;
    end
    // Walk oldest to youngest so the youngest match is the last assignment.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].regsel == sel)) begin
        hit  = 1'b1;
        data = entries[i].data;
      end
    end
  end

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue in front of the 8x16 register file: buffers requests,
// drains one per cycle, forwards pending values to both read selectors.
// Optional RF_WB_COALESCE_EN: pushes to a register already queued overwrite it.
module rf_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int SEL_W  = rf_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [SEL_W-1:0]  wb_regsel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              drain_en,
  output logic [SEL_W-1:0]  writeregsel,
  output logic [DATA_W-1:0] writedata,
  output logic              write,
  input  logic [SEL_W-1:0]  read1regsel,
  input  logic [SEL_W-1:0]  read2regsel,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a request transfers on an edge where wb_valid and wb_ready are
  // both 1; wb_ready is a function of pre-edge state (and, with coalescing,
  // of wb_regsel) and never of wb_valid. wb_valid with wb_ready=0 is an
  // overflow: the request is dropped and err latches.

  rf_pkg::wb_entry_t [DEPTH-1:0] mem;
  rf_pkg::wb_entry_t [DEPTH-1:0] by_age;
  rf_pkg::wb_entry_t             out_q;

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             full;
  logic             empty;
  logic             pop;
  logic             coal;
  logic             alloc;
  logic             overflow;

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
  assign pop    = drain_en && !empty;

`ifdef RF_WB_COALESCE_EN
  logic             match;
  logic [PTR_W-1:0] match_idx;

  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid && (mem[i].regsel == wb_regsel)) begin
        match     = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
  end

  // A match on the head that leaves this edge cannot be patched in place;
  // the request takes the slot the pop frees instead.
  assign coal     = wb_valid && match && !(pop && (match_idx == rd_idx));
  assign wb_ready = !full || match;
`else
  assign coal     = 1'b0;
  assign wb_ready = !full;
`endif

  assign alloc    = wb_valid && wb_ready && !coal;
  assign overflow = wb_valid && !wb_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
      out_q  <= '0;
      err    <= 1'b0;
    end else begin
      if (pop) begin
        out_q             <= mem[rd_idx];
        out_q.valid       <= 1'b1;
        mem[rd_idx].valid <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end else begin
        out_q.valid <= 1'b0;
      end
`ifdef RF_WB_COALESCE_EN
      if (coal) begin
        mem[match_idx].data <= wb_data;
      end
`endif
      // When full, alloc reuses the slot being popped; this write must win.
      if (alloc) begin
        mem[wr_idx] <= '{valid: 1'b1, regsel: wb_regsel, data: wb_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (overflow) begin
        err <= 1'b1;
      end
    end
  end

  assign write       = out_q.valid;
  assign writeregsel = out_q.regsel;
  assign writedata   = out_q.data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      by_age[i] = mem[wr_idx - PTR_W'(i + 1)];
    end
  end

  rf_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries   (by_age),
    .out_entry (out_q),
    .sel       (read1regsel),
    .hit       (fwd1_hit),
    .data      (fwd1_data)
  );

  rf_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries   (by_age),
    .out_entry (out_q),
    .sel       (read2regsel),
    .hit       (fwd2_hit),
    .data      (fwd2_data)
  );

endmodule
